cordic_iter_writeback: RTL and testbench
========================================

// Module: cordic_iter_writeback
// PURPOSE
//  Sits directly downstream of the execute pipeline and consumes X/Y/Z/K_next, mode, operation,
//  NatLogFlag and InsTag on each ALU_done pulse. Decides per instruction whether to recirculate
//  for another CORDIC iteration (feedback FIFO back to the FSM) or retire it (result FIFO, valid/ready).
//  Tracks the per-tag iteration count and raises a stall toward the issue FSM.
// PARAMETERS
//  MAX_ITER    24   retire unconditionally once this many iterations have completed
//  EXP_THRESH  8'd103  converged when biased exponent of the tested operand < EXP_THRESH (|v| < 2^-24)
//  TAG_W       8    tag bits used to index the iteration-count table (2^TAG_W entries)
//  FIFO_DEPTH  4    depth of the result FIFO and of the feedback FIFO (power of 2, >= 2)
//  STALL_SLACK 2    stall_out asserts when either FIFO has <= STALL_SLACK free slots
// PORTS
//  clock          in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-low; 0 clears all state
//  X_in/Y_in/Z_in/K_in  in   32  IEEE-754 single results from the execute stage
//  mode_in        in   2   CORDIC mode carried with the data
//  operation_in   in   1   1 = rotation (Z tested), 0 = vectoring (Y tested)
//  NatLogFlag_in  in   1   natural-log flag carried with the data
//  InsTag_in      in   8   instruction tag
//  ALU_done       in   1   qualifies all *_in fields this cycle
//  fb_valid       out  1   feedback head valid;  fb_ready in 1: FSM accepts feedback head
//  fb_X/fb_Y/fb_Z/fb_K out 32; fb_mode out 2; fb_operation/fb_NatLogFlag out 1; fb_InsTag out 8
//  res_valid      out  1   result head valid;   res_ready in 1: consumer accepts result head
//  res_X/res_Y/res_Z/res_K out 32; res_mode out 2; res_NatLogFlag out 1; res_InsTag out 8
//  stall_out      out  1   upstream must stop issuing new instructions/iterations
//  overflow_err   out  1   sticky: an ALU_done entry was dropped because its target FIFO was full
// BEHAVIOUR
//  - Reset: all FIFOs empty, fb_valid=res_valid=0, all data outputs 0, stall_out=0, overflow_err=0,
//    iteration table all 0. Reset mid-operation discards every in-flight entry; no partial outputs.
//  - Classification, same cycle as ALU_done: n = table[InsTag_in[TAG_W-1:0]] + 1.
//    tested = operation_in ? Z_in : Y_in; conv = (tested[30:23] < EXP_THRESH) (covers +-0/denormals).
//    RETIRE if conv || n >= MAX_ITER, else RECIRC.
//  - RETIRE: push {X,Y,Z,K,mode,NatLogFlag,tag} to result FIFO; table entry <= 0 next edge.
//    RECIRC: push {X,Y,Z,K,mode,operation,NatLogFlag,tag} to feedback FIFO; table entry <= n.
//  - Latency: entry visible at FIFO head (valid high) 1 cycle after the ALU_done edge if FIFO was empty.
//  - Handshake: head pops on clock edge where valid && ready; valid/data stay stable until popped.
//    Simultaneous push and pop on a full FIFO is legal (pop frees the slot) and never overflows.
//  - Push to a full FIFO with no same-cycle pop: entry dropped, table NOT updated, overflow_err <= 1
//    (cleared only by reset).
//  - stall_out registered: 1 when free(result) <= STALL_SLACK or free(feedback) <= STALL_SLACK.
//  - Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1 distinguishes full from empty.
//  - ALU_done=0: no push, table unchanged; *_in ignored.
// CONFIGURATION
//  ITER_STATS_EN defined: adds ports res_iter out 6 (iterations taken, carried with each result
//    entry) and iter_total out 32 (saturating count of all classified ALU_done pulses, reset 0).
//  Not defined: neither port exists; result FIFO width excludes the iteration field.
// STRUCTURE
//  Shared package/header: entry field widths, EXP field bit positions [30:23], mode encodings,
//  default MAX_ITER/EXP_THRESH constants. One sub-module: cordic_wb_fifo (parameterised width/depth
//  sync FIFO with push/pop/full/empty/free count), instantiated twice; table and classifier in top.
// TESTING
//  1 Rotation, Z_in=32'h33000000 (2^-25), ALU_done 1 cycle, tag 5 -> res_valid next cycle, res_InsTag=5,
//    fb_valid stays 0, table[5]=0.
//  2 Vectoring, Y_in=32'h3F800000 for tag 7, 24 ALU_done pulses -> 23 feedback pushes then a retire on
//    the 24th; res_iter=24 with ITER_STATS_EN.
//  3 res_ready=0, 4 retiring pulses -> stall_out 1 after 2nd push; 5th pulse -> dropped,
//    overflow_err=1; then res_ready=1 -> 4 results out in push order.
//  4 Full result FIFO, res_ready=1 and retiring ALU_done same cycle -> no drop, count stays 4.
//  5 Drop reset low mid-stream with both FIFOs non-empty -> all valids 0, stall_out 0, overflow_err 0
//    asynchronously; tag reused afterwards starts at n=1.
//  6 Interleaved tags 1 and 2 recirculating -> independent counts; tag 1 retiring clears only table[1].

Source files
------------

// File: rtl/cordic_iter_writeback_pkg.sv
// Shared widths, exponent field position and default limits for the CORDIC iteration writeback stage.
// ITER_STATS_EN adds the iteration count to each result entry.
package cordic_iter_writeback_pkg;
   localparam int DATA_W  = 32;
   localparam int MODE_W  = 2;
   localparam int TAG_FW  = 8;
   localparam int ITER_W  = 6;
   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;

   localparam int              DEF_MAX_ITER   = 24;
   localparam logic [7:0]      DEF_EXP_THRESH = 8'd103;

   typedef enum logic [MODE_W-1:0] {
      MODE_CIRC = 2'd0,
      MODE_LIN  = 2'd1,
      MODE_HYP  = 2'd2,
      MODE_RSVD = 2'd3
   } cordic_mode_e;

   typedef struct packed {
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
      logic [DATA_W-1:0] z;
      logic [DATA_W-1:0] k;
      logic [MODE_W-1:0] mode;
      logic              op;
      logic              nlf;
      logic [TAG_FW-1:0] tag;
   } fb_entry_t;

   typedef struct packed {
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
      logic [DATA_W-1:0] z;
      logic [DATA_W-1:0] k;
      logic [MODE_W-1:0] mode;
      logic              nlf;
      logic [TAG_FW-1:0] tag;
`ifdef ITER_STATS_EN
      logic [ITER_W-1:0] iter;
`endif
   } res_entry_t;

   function automatic logic [7:0] exp_field(input logic [DATA_W-1:0] v);
      return v[EXP_MSB:EXP_LSB];
   endfunction
endpackage

// File: rtl/cordic_iter_writeback_fifo.sv
// cordic_wb_fifo: synchronous FIFO with valid-gated pop; a pop on a full FIFO frees the slot
// for a same-cycle push. Storage is cleared on reset so outputs read 0 after reset.
module cordic_wb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic          push_ok,
   output logic          empty,
   output logic [CW-1:0] free_nxt,
   output logic [W-1:0]  dout
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pop_ok;

   assign pop_ok   = pop && (cnt != '0);
   assign push_ok  = push && ((cnt != CW'(DEPTH)) || pop_ok);
   assign cnt_nxt  = cnt + CW'(push_ok) - CW'(pop_ok);
   assign free_nxt = CW'(DEPTH) - cnt_nxt;
   assign empty    = (cnt == '0);
   assign dout     = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt_nxt;
      end
   end
endmodule

// File: rtl/cordic_iter_writeback.sv
// Retire/recirculate decision for CORDIC iterations with per-tag iteration table.
// ITER_STATS_EN adds res_iter and iter_total outputs.
module cordic_iter_writeback
   import cordic_iter_writeback_pkg::*;
#(
   parameter int         MAX_ITER    = DEF_MAX_ITER,
   parameter logic [7:0] EXP_THRESH  = DEF_EXP_THRESH,
   parameter int         TAG_W       = 8,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         STALL_SLACK = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] X_in,
   input  logic [31:0] Y_in,
   input  logic [31:0] Z_in,
   input  logic [31:0] K_in,
   input  logic [1:0]  mode_in,
   input  logic        operation_in,
   input  logic        NatLogFlag_in,
   input  logic [7:0]  InsTag_in,
   input  logic        ALU_done,
   output logic        fb_valid,
   input  logic        fb_ready,
   output logic [31:0] fb_X,
   output logic [31:0] fb_Y,
   output logic [31:0] fb_Z,
   output logic [31:0] fb_K,
   output logic [1:0]  fb_mode,
   output logic        fb_operation,
   output logic        fb_NatLogFlag,
   output logic [7:0]  fb_InsTag,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_X,
   output logic [31:0] res_Y,
   output logic [31:0] res_Z,
   output logic [31:0] res_K,
   output logic [1:0]  res_mode,
   output logic        res_NatLogFlag,
   output logic [7:0]  res_InsTag,
`ifdef ITER_STATS_EN
   output logic [5:0]  res_iter,
   output logic [31:0] iter_total,
`endif
   output logic        stall_out,
   output logic        overflow_err
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [ITER_W-1:0] iter_tbl [2**TAG_W];
   logic [TAG_W-1:0]  idx;
   logic [ITER_W-1:0] n;
   logic              conv, retire, accepted;
   logic              res_push_ok, fb_push_ok, res_empty, fb_empty;
   logic [CW-1:0]     res_free_nxt, fb_free_nxt;
   res_entry_t        res_din, res_dout;
   fb_entry_t         fb_din, fb_dout;

   // Rotation drives Z toward zero, vectoring drives Y; a small exponent means converged.
   assign idx      = InsTag_in[TAG_W-1:0];
   assign n        = iter_tbl[idx] + 1'b1;
   assign conv     = exp_field(operation_in ? Z_in : Y_in) < EXP_THRESH;
   assign retire   = conv || (n >= ITER_W'(MAX_ITER));
   assign accepted = retire ? res_push_ok : fb_push_ok;

   always_comb begin
      res_din      = '0;
      res_din.x    = X_in;
      res_din.y    = Y_in;
      res_din.z    = Z_in;
      res_din.k    = K_in;
      res_din.mode = mode_in;
      res_din.nlf  = NatLogFlag_in;
      res_din.tag  = InsTag_in;
`ifdef ITER_STATS_EN
      res_din.iter = n;
`endif
      fb_din      = '{x: X_in, y: Y_in, z: Z_in, k: K_in, mode: mode_in,
                      op: operation_in, nlf: NatLogFlag_in, tag: InsTag_in};
   end

   cordic_wb_fifo #(.W($bits(res_entry_t)), .DEPTH(FIFO_DEPTH)) u_res_fifo (
      .clock(clock), .reset(reset),
      .push(ALU_done && retire), .pop(res_ready), .din(res_din),
      .push_ok(res_push_ok), .empty(res_empty), .free_nxt(res_free_nxt), .dout(res_dout)
   );

   cordic_wb_fifo #(.W($bits(fb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fb_fifo (
      .clock(clock), .reset(reset),
      .push(ALU_done && !retire), .pop(fb_ready), .din(fb_din),
      .push_ok(fb_push_ok), .empty(fb_empty), .free_nxt(fb_free_nxt), .dout(fb_dout)
   );

   // A dropped entry leaves its table slot untouched so a replay sees the same count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2**TAG_W; i++) iter_tbl[i] <= '0;
         overflow_err <= 1'b0;
         stall_out    <= 1'b0;
      end else begin
         if (ALU_done && accepted) iter_tbl[idx] <= retire ? '0 : n;
         if (ALU_done && !accepted) overflow_err <= 1'b1;
         stall_out <= (res_free_nxt <= CW'(STALL_SLACK)) || (fb_free_nxt <= CW'(STALL_SLACK));
      end
   end

`ifdef ITER_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                          iter_total <= '0;
      else if (ALU_done && iter_total != '1) iter_total <= iter_total + 1'b1;
   end
   assign res_iter = res_dout.iter;
`endif

   assign res_valid      = !res_empty;
   assign res_X          = res_dout.x;
   assign res_Y          = res_dout.y;
   assign res_Z          = res_dout.z;
   assign res_K          = res_dout.k;
   assign res_mode       = res_dout.mode;
   assign res_NatLogFlag = res_dout.nlf;
   assign res_InsTag     = res_dout.tag;

   assign fb_valid      = !fb_empty;
   assign fb_X          = fb_dout.x;
   assign fb_Y          = fb_dout.y;
   assign fb_Z          = fb_dout.z;
   assign fb_K          = fb_dout.k;
   assign fb_mode       = fb_dout.mode;
   assign fb_operation  = fb_dout.op;
   assign fb_NatLogFlag = fb_dout.nlf;
   assign fb_InsTag     = fb_dout.tag;
endmodule

// File: tb/tb_cordic_iter_writeback.sv
// Directed bench with queue scoreboards for the result and feedback FIFOs and a reference
// iteration table; build with ITER_STATS_EN to also cover res_iter / iter_total.
module tb_cordic_iter_writeback;
   logic        clock = 1'b0, reset = 1'b0;
   logic [31:0] X_in = '0, Y_in = '0, Z_in = '0, K_in = '0;
   logic [1:0]  mode_in = '0;
   logic        operation_in = 1'b0, NatLogFlag_in = 1'b0, ALU_done = 1'b0;
   logic [7:0]  InsTag_in = '0;
   logic        fb_valid, fb_ready = 1'b0, res_valid, res_ready = 1'b0;
   logic [31:0] fb_X, fb_Y, fb_Z, fb_K, res_X, res_Y, res_Z, res_K;
   logic [1:0]  fb_mode, res_mode;
   logic        fb_operation, fb_NatLogFlag, res_NatLogFlag, stall_out, overflow_err;
   logic [7:0]  fb_InsTag, res_InsTag;
`ifdef ITER_STATS_EN
   logic [5:0]  res_iter;
   logic [31:0] iter_total;
`endif

   cordic_iter_writeback dut (
      .clock(clock), .reset(reset),
      .X_in(X_in), .Y_in(Y_in), .Z_in(Z_in), .K_in(K_in), .mode_in(mode_in),
      .operation_in(operation_in), .NatLogFlag_in(NatLogFlag_in), .InsTag_in(InsTag_in),
      .ALU_done(ALU_done),
      .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_X(fb_X), .fb_Y(fb_Y), .fb_Z(fb_Z),
      .fb_K(fb_K), .fb_mode(fb_mode), .fb_operation(fb_operation),
      .fb_NatLogFlag(fb_NatLogFlag), .fb_InsTag(fb_InsTag),
      .res_valid(res_valid), .res_ready(res_ready), .res_X(res_X), .res_Y(res_Y),
      .res_Z(res_Z), .res_K(res_K), .res_mode(res_mode), .res_NatLogFlag(res_NatLogFlag),
      .res_InsTag(res_InsTag),
`ifdef ITER_STATS_EN
      .res_iter(res_iter), .iter_total(iter_total),
`endif
      .stall_out(stall_out), .overflow_err(overflow_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] x, y, z, k;
      logic [1:0]  mode;
      logic        op, nlf;
      logic [7:0]  tag;
      int          iter;
   } ent_t;

   ent_t rq[$], fq[$];
   int   mtab [256];
   bit   movf;
   int   mtotal;
   int   vectors = 0, miscompares = 0;

   localparam logic [31:0] ONE  = 32'h3F80_0000;  // exponent 127, not converged
   localparam logic [31:0] TINY = 32'h3300_0000;  // 2^-25, exponent 102, converged

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic check_outputs();
      ent_t e;
      chk("res_valid", res_valid, rq.size() != 0);
      if (rq.size() != 0) begin
         e = rq[0];
         chk("res_head", {res_X, res_Y, res_Z, res_K, res_mode, res_NatLogFlag, res_InsTag},
             {e.x, e.y, e.z, e.k, e.mode, e.nlf, e.tag});
`ifdef ITER_STATS_EN
         chk("res_iter", res_iter, 6'(e.iter));
`endif
      end
      chk("fb_valid", fb_valid, fq.size() != 0);
      if (fq.size() != 0) begin
         e = fq[0];
         chk("fb_head", {fb_X, fb_Y, fb_Z, fb_K, fb_mode, fb_operation, fb_NatLogFlag, fb_InsTag},
             {e.x, e.y, e.z, e.k, e.mode, e.op, e.nlf, e.tag});
      end
      chk("stall_out", stall_out, (4 - rq.size() <= 2) || (4 - fq.size() <= 2));
      chk("overflow_err", overflow_err, movf);
`ifdef ITER_STATS_EN
      chk("iter_total", iter_total, mtotal);
`endif
   endtask

   // One clock: drive inputs, predict the edge with the reference model, then compare.
   task automatic tick(input bit done, input logic [31:0] y, input logic [31:0] z, input bit op,
                       input logic [7:0] tag, input bit rr, input bit fr);
      ent_t e;
      bit   rpop, fpop, ret, ok;
      int   n;
      e.x = {tag, 8'hA5, tag, 8'h3C} ^ y;
      e.y = y; e.z = z; e.k = e.x ^ 32'h0F0F_0F0F;
      e.mode = tag[1:0]; e.op = op; e.nlf = tag[2]; e.tag = tag;
      ALU_done = done; X_in = e.x; Y_in = y; Z_in = z; K_in = e.k;
      mode_in = e.mode; operation_in = op; NatLogFlag_in = e.nlf; InsTag_in = tag;
      res_ready = rr; fb_ready = fr;
      rpop = rr && rq.size() > 0;
      fpop = fr && fq.size() > 0;
      n = mtab[tag] + 1;
      ret = ((op ? z[30:23] : y[30:23]) < 8'd103) || n >= 24;
      e.iter = n;
      ok = ret ? (rq.size() < 4 || rpop) : (fq.size() < 4 || fpop);
      @(posedge clock); #1;
      if (rpop) void'(rq.pop_front());
      if (fpop) void'(fq.pop_front());
      if (done) begin
         mtotal++;
         if (!ok) movf = 1'b1;
         else if (ret) begin rq.push_back(e); mtab[tag] = 0; end
         else begin fq.push_back(e); mtab[tag] = n; end
      end
      ALU_done = 1'b0; res_ready = 1'b0; fb_ready = 1'b0;
      check_outputs();
   endtask

   task automatic model_reset();
      rq.delete(); fq.delete();
      foreach (mtab[i]) mtab[i] = 0;
      movf = 1'b0; mtotal = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1);
   end

   initial begin
      model_reset();
      #12;
      chk("rst_res_X", res_X, 32'h0);
      chk("rst_fb_InsTag", fb_InsTag, 8'h0);
      check_outputs();
      @(posedge clock); #1 reset = 1'b1;

      // Rotation with a tiny Z retires immediately.
      tick(1, ONE, TINY, 1'b1, 8'd5, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);

      // Vectoring on tag 7: 23 recirculations, retire on the 24th pass.
      for (int i = 0; i < 24; i++) tick(1, ONE, ONE, 1'b0, 8'd7, 0, 1);
      tick(0, 0, 0, 0, 0, 1, 1);

      // Back-pressure: fill the result FIFO, drop the fifth, then push-with-pop on full.
      for (int i = 0; i < 5; i++) tick(1, ONE, 32'h0, 1'b1, 8'(8'h10 + i), 0, 0);
      tick(1, ONE, 32'h8000_0000, 1'b1, 8'h15, 1, 0);
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 1, 0);

      // Reset mid-stream with tag 9 one pass from its limit and both FIFOs occupied.
      for (int i = 0; i < 23; i++) tick(1, ONE, ONE, 1'b0, 8'd9, 0, 1);
      tick(1, ONE, ONE, 1'b0, 8'd10, 0, 0);
      tick(1, ONE, TINY, 1'b1, 8'd11, 0, 0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk("async_res_valid", res_valid, 1'b0);
      chk("async_fb_valid", fb_valid, 1'b0);
      chk("async_stall", stall_out, 1'b0);
      chk("async_ovf", overflow_err, 1'b0);
      @(posedge clock); #1 reset = 1'b1;
      tick(1, ONE, ONE, 1'b0, 8'd9, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 1);

      // Interleaved tags 1 and 2; retiring tag 1 must leave tag 2's count intact.
      for (int i = 0; i < 22; i++) begin
         tick(1, ONE, ONE, 1'b0, 8'd1, 0, 1);
         tick(1, ONE, ONE, 1'b0, 8'd2, 0, 1);
      end
      tick(1, TINY, ONE, 1'b0, 8'd1, 0, 1);
      tick(1, ONE, ONE, 1'b0, 8'd2, 1, 1);
      tick(1, ONE, ONE, 1'b0, 8'd2, 0, 1);
      tick(1, ONE, ONE, 1'b0, 8'd1, 1, 1);
      tick(0, 0, 0, 0, 0, 1, 1);
      tick(0, 0, 0, 0, 0, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
